// File: rtl/ql_keybuf.sv
// PS/2 set-2 to QL keyboard front end: live 8x8 KEYROW matrix plus a queue of key presses for the IPC.
// Latency: a toggle in cycle N is queued and visible at N+3. No backpressure: a push into a full queue is dropped and kbd_ovf is set.

module ql_keybuf_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr] <= din;
  end
endmodule

module ql_keybuf #(
  parameter int FIFO_DEPTH       = 8,
  parameter bit IGNORE_TYPEMATIC = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [10:0]                   ps2_key,
  input  logic                          flush,
  input  logic                          kbd_pop,
  output logic                          kbd_avail,
  output logic [$clog2(FIFO_DEPTH):0]   kbd_count,
  output logic [5:0]                    kbd_code,
  output logic [2:0]                    kbd_mods,
  output logic                          kbd_ovf,
  input  logic [2:0]                    row_sel,
  output logic [7:0]                    row_data,
  output logic [2:0]                    mods_now
);
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  logic        tog_q;
  logic        s1_vld;
  ev_t         s1_dat;
  logic        s2_vld;
  ev_t         s2_dat;
  logic [63:0] matrix;
  logic        map_hit;
  logic [5:0]  map_key;
  logic        key_held;
  logic        is_mod;
  logic        upd;
  logic        push_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  fifo_dout;

  // Toggle history follows ps2_key[10] through reset so release never looks like an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q  <= ps2_key[10];
      s1_vld <= 1'b0;
      s1_dat <= '0;
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else begin
      tog_q  <= ps2_key[10];
      s1_vld <= (ps2_key[10] != tog_q) && !flush;
      s1_dat <= ps2_key[9:0];
      s2_vld <= s1_vld && !flush;
      s2_dat <= s1_dat;
    end
  end

  // QL KEYROW layout, key = row*8 + col.
  always_comb begin
    map_hit = 1'b1;
    map_key = 6'h00;
    case ({s2_dat.ext, s2_dat.code})
      9'h00C: map_key = 6'h00; // F4
      9'h005: map_key = 6'h01; // F1
      9'h02E: map_key = 6'h02; // 5
      9'h006: map_key = 6'h03; // F2
      9'h004: map_key = 6'h04; // F3
      9'h003: map_key = 6'h05; // F5
      9'h025: map_key = 6'h06; // 4
      9'h03D: map_key = 6'h07; // 7
      9'h05A: map_key = 6'h08; // Enter
      9'h16B: map_key = 6'h09; // Left
      9'h175: map_key = 6'h0A; // Up
      9'h076: map_key = 6'h0B; // Esc
      9'h174: map_key = 6'h0C; // Right
      9'h05D: map_key = 6'h0D; // backslash
      9'h029: map_key = 6'h0E; // Space
      9'h172: map_key = 6'h0F; // Down
      9'h05B: map_key = 6'h10; // ]
      9'h01A: map_key = 6'h11; // z
      9'h049: map_key = 6'h12; // .
      9'h021: map_key = 6'h13; // c
      9'h032: map_key = 6'h14; // b
      9'h00E: map_key = 6'h15; // backtick as pound
      9'h03A: map_key = 6'h16; // m
      9'h052: map_key = 6'h17; // '
      9'h054: map_key = 6'h18; // [
      9'h058: map_key = 6'h19; // Caps Lock
      9'h042: map_key = 6'h1A; // k
      9'h01B: map_key = 6'h1B; // s
      9'h02B: map_key = 6'h1C; // f
      9'h055: map_key = 6'h1D; // =
      9'h034: map_key = 6'h1E; // g
      9'h04C: map_key = 6'h1F; // ;
      9'h04B: map_key = 6'h20; // l
      9'h026: map_key = 6'h21; // 3
      9'h033: map_key = 6'h22; // h
      9'h016: map_key = 6'h23; // 1
      9'h01C: map_key = 6'h24; // a
      9'h04D: map_key = 6'h25; // p
      9'h023: map_key = 6'h26; // d
      9'h03B: map_key = 6'h27; // j
      9'h046: map_key = 6'h28; // 9
      9'h01D: map_key = 6'h29; // w
      9'h043: map_key = 6'h2A; // i
      9'h00D: map_key = 6'h2B; // Tab
      9'h02D: map_key = 6'h2C; // r
      9'h04E: map_key = 6'h2D; // -
      9'h035: map_key = 6'h2E; // y
      9'h044: map_key = 6'h2F; // o
      9'h03E: map_key = 6'h30; // 8
      9'h01E: map_key = 6'h31; // 2
      9'h036: map_key = 6'h32; // 6
      9'h015: map_key = 6'h33; // q
      9'h024: map_key = 6'h34; // e
      9'h045: map_key = 6'h35; // 0
      9'h02C: map_key = 6'h36; // t
      9'h03C: map_key = 6'h37; // u
      9'h012, 9'h059: map_key = 6'h38; // Shift L/R
      9'h014, 9'h114: map_key = 6'h39; // Ctrl L/R
      9'h011, 9'h111: map_key = 6'h3A; // Alt L/R
      9'h022: map_key = 6'h3B; // x
      9'h02A: map_key = 6'h3C; // v
      9'h04A: map_key = 6'h3D; // /
      9'h031: map_key = 6'h3E; // n
      9'h041: map_key = 6'h3F; // ,
      default: map_hit = 1'b0;
    endcase
  end

  always_comb begin
    key_held = matrix[map_key];
    is_mod   = (map_key[5:3] == 3'd7) && (map_key[2:0] < 3'd3);
    upd      = s2_vld && map_hit && !flush;
    push_req = upd && s2_dat.pressed && !is_mod && !(IGNORE_TYPEMATIC && key_held);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      matrix  <= '0;
      kbd_ovf <= 1'b0;
    end else begin
      if (flush)    matrix          <= '0;
      else if (upd) matrix[map_key] <= s2_dat.pressed;

      if (flush || kbd_pop)                   kbd_ovf <= 1'b0;
      else if (push_req && fifo_full)         kbd_ovf <= 1'b1;
    end
  end

  // Modifier state lives in row 7 cols 2..0, so it is simply a view of the matrix.
  assign mods_now = matrix[58:56];
  assign row_data = matrix[{row_sel, 3'b000} +: 8];

  ql_keybuf_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (flush),
    .push  (push_req),
    .pop   (kbd_pop),
    .din   ({mods_now, map_key}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (kbd_count),
    .dout  (fifo_dout)
  );

  assign kbd_avail = !fifo_empty;
  assign kbd_mods  = fifo_dout[8:6];
  assign kbd_code  = fifo_dout[5:0];
endmodule

// File: tb/tb_ql_keybuf.sv
// Directed bench for ql_keybuf: hand-computed matrix/queue expectations, checked one cycle-offset after each event.

module tb_ql_keybuf;
  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        flush;
  logic        kbd_pop;
  logic        kbd_avail;
  logic [3:0]  kbd_count;
  logic [5:0]  kbd_code;
  logic [2:0]  kbd_mods;
  logic        kbd_ovf;
  logic [2:0]  row_sel;
  logic [7:0]  row_data;
  logic [2:0]  mods_now;

  int n_tests = 0;
  int n_fail  = 0;

  ql_keybuf #(.FIFO_DEPTH(8), .IGNORE_TYPEMATIC(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .flush     (flush),
    .kbd_pop   (kbd_pop),
    .kbd_avail (kbd_avail),
    .kbd_count (kbd_count),
    .kbd_code  (kbd_code),
    .kbd_mods  (kbd_mods),
    .kbd_ovf   (kbd_ovf),
    .row_sel   (row_sel),
    .row_data  (row_data),
    .mods_now  (mods_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
    drive(pressed, ext, code);
    tick(3);
  endtask

  task automatic pop1();
    kbd_pop = 1'b1;
    tick(1);
    kbd_pop = 1'b0;
  endtask

  logic [7:0] fill_sc  [9];
  logic [5:0] fill_key [9];

  initial begin
    fill_sc  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    fill_key = '{6'h24, 6'h14, 6'h13, 6'h26, 6'h34, 6'h1C, 6'h1E, 6'h22, 6'h2A};

    reset_n = 1'b0;
    ps2_key = 11'h400;
    flush   = 1'b0;
    kbd_pop = 1'b0;
    row_sel = 3'd0;
    tick(3);
    check("rst_count", 32'(kbd_count), 0);
    check("rst_avail", 32'(kbd_avail), 0);
    check("rst_ovf",   32'(kbd_ovf), 0);
    check("rst_code",  32'(kbd_code), 0);
    check("rst_mods",  32'(mods_now), 0);
    reset_n = 1'b1;
    tick(4);
    check("no_spurious_count", 32'(kbd_count), 0);

    // Enter: visible exactly three cycles after the toggle
    drive(1'b1, 1'b0, 8'h5A);
    tick(2);
    check("enter_avail_n2", 32'(kbd_avail), 0);
    tick(1);
    check("enter_avail_n3", 32'(kbd_avail), 1);
    check("enter_code", 32'(kbd_code), 32'h08);
    check("enter_mods", 32'(kbd_mods), 0);
    row_sel = 3'd1;
    #1;
    check("enter_row1", 32'(row_data), 32'h01);
    pop1();
    send(1'b0, 1'b0, 8'h5A);
    check("enter_break_row1", 32'(row_data), 0);
    check("enter_popped", 32'(kbd_count), 0);

    // Shift + Space
    send(1'b1, 1'b0, 8'h12);
    check("shift_mods_now", 32'(mods_now), 32'h1);
    check("shift_no_push", 32'(kbd_count), 0);
    row_sel = 3'd7;
    #1;
    check("shift_row7", 32'(row_data), 32'h01);
    send(1'b1, 1'b0, 8'h29);
    check("space_count", 32'(kbd_count), 1);
    check("space_code", 32'(kbd_code), 32'h0E);
    check("space_mods", 32'(kbd_mods), 32'h1);
    send(1'b0, 1'b0, 8'h12);
    check("lshift_break", 32'(mods_now), 0);
    send(1'b0, 1'b0, 8'h59);
    check("rshift_break", 32'(mods_now), 0);
    send(1'b0, 1'b0, 8'h29);
    row_sel = 3'd1;
    #1;
    check("space_break_row1", 32'(row_data), 0);
    check("space_break_nopush", 32'(kbd_count), 1);
    send(1'b1, 1'b1, 8'h14);
    check("rctrl_mods", 32'(mods_now), 32'h2);
    send(1'b0, 1'b1, 8'h14);
    check("rctrl_break", 32'(mods_now), 0);
    pop1();

    // Typematic repeats dropped
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 8'h29);
    check("typematic_count", 32'(kbd_count), 1);
    send(1'b0, 1'b0, 8'h29);
    pop1();
    check("typematic_popped", 32'(kbd_count), 0);

    // Overflow with 9 distinct keys
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, fill_sc[i]);
    check("ovf_count", 32'(kbd_count), 8);
    check("ovf_flag", 32'(kbd_ovf), 1);
    check("ovf_head", 32'(kbd_code), 32'(fill_key[0]));
    row_sel = 3'd5;
    #1;
    check("ovf_matrix_still_set", 32'(row_data), 32'h04);
    pop1();
    check("pop_clears_ovf", 32'(kbd_ovf), 0);
    check("pop_count", 32'(kbd_count), 7);
    check("pop_head", 32'(kbd_code), 32'(fill_key[1]));
    send(1'b1, 1'b0, 8'h42);
    check("refill_count", 32'(kbd_count), 8);
    check("refill_ovf", 32'(kbd_ovf), 0);
    drive(1'b1, 1'b0, 8'h3B);
    tick(2);
    kbd_pop = 1'b1;
    tick(1);
    kbd_pop = 1'b0;
    check("full_pushpop_count", 32'(kbd_count), 8);
    check("full_pushpop_ovf", 32'(kbd_ovf), 0);
    check("full_pushpop_head", 32'(kbd_code), 32'(fill_key[2]));
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush1_count", 32'(kbd_count), 0);

    // Extended vs plain 0x75
    send(1'b1, 1'b1, 8'h75);
    check("up_count", 32'(kbd_count), 1);
    check("up_code", 32'(kbd_code), 32'h0A);
    send(1'b1, 1'b0, 8'h75);
    check("kp8_count", 32'(kbd_count), 1);
    row_sel = 3'd1;
    #1;
    check("kp8_row1", 32'(row_data), 32'h04);

    // Flush with keys held and entries queued
    send(1'b1, 1'b0, 8'h5A);
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h29);
    check("preflush_count", 32'(kbd_count), 3);
    check("preflush_mods", 32'(mods_now), 32'h1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_count", 32'(kbd_count), 0);
    check("flush_avail", 32'(kbd_avail), 0);
    check("flush_mods", 32'(mods_now), 0);
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      #1;
      check($sformatf("flush_row%0d", r), 32'(row_data), 0);
    end
    pop1();
    check("empty_pop_count", 32'(kbd_count), 0);
    check("empty_pop_avail", 32'(kbd_avail), 0);
    check("empty_pop_code", 32'(kbd_code), 0);

    // Flush while an event sits in stage 1, then in stage 2
    row_sel = 3'd4;
    drive(1'b1, 1'b0, 8'h1C);
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    check("flush_s1_count", 32'(kbd_count), 0);
    check("flush_s1_row4", 32'(row_data), 0);
    drive(1'b1, 1'b0, 8'h1C);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(2);
    check("flush_s2_count", 32'(kbd_count), 0);
    check("flush_s2_row4", 32'(row_data), 0);

    // Reset while an event is in flight
    drive(1'b1, 1'b0, 8'h1C);
    tick(1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(4);
    check("midrst_count", 32'(kbd_count), 0);
    check("midrst_row4", 32'(row_data), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
